// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared definitions for the multi-channel clock divider.
//   chan_state_e : per-channel state (IDLE / RUN)
//   MIN_RATIO    : smallest ratio that actually divides; below it the channel bypasses
//   high_len()   : cycles the divided clock stays high in one period, ceil(R/2)
package clk_div_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_e;

   localparam int unsigned MIN_RATIO = 2;

   // Wide enough for any ratio width this block is built with.
   localparam int unsigned FN_W = 16;

   function automatic logic [FN_W-1:0] high_len(input logic [FN_W-1:0] ratio);
      return ratio - (ratio >> 1);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan
// One divider channel: state, period timer, shadow ratio, divided level and tick.
// Ports:
//   clk_sys   in   reference clock
//   rst       in   synchronous, active-high reset
//   clk_en    in   channel enable (honoured at period boundaries)
//   div_ratio in   requested ratio (latched at period boundaries)
//   sync      in   restart pulse shared by all channels
//   div_q     out  divided clock level (meaningful while running)
//   tick_q    out  one-cycle pulse in the first cycle of each high phase
//   running   out  channel is in RUN
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | not dividing; shadow ratio tracks div_ratio, output bypassed
// ST_RUN  | dividing; cnt_q counts down the cycles left in the period
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned RATIO_W = 8
) (
   input  logic               clk_sys,
   input  logic               rst,
   input  logic               clk_en,
   input  logic [RATIO_W-1:0] div_ratio,
   input  logic               sync,
   output logic               div_q,
   output logic               tick_q,
   output logic               running
);

   localparam logic [RATIO_W-1:0] MIN_R = RATIO_W'(MIN_RATIO);
   localparam logic [RATIO_W-1:0] ONE   = RATIO_W'(1);

   chan_state_e        state_q, state_d;
   logic [RATIO_W-1:0] cnt_q, cnt_d;
   logic [RATIO_W-1:0] ratio_q, ratio_d;
   logic               div_d;
   logic               tick_d;

   logic               ratio_ok;
   logic [RATIO_W-1:0] cnt_next;
   logic [FN_W-1:0]    ratio_ext;
   logic [RATIO_W-1:0] low_len;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ratio_d   = ratio_q;
      div_d     = div_q;
      tick_d    = 1'b0;

      ratio_ok  = (div_ratio >= MIN_R);
      cnt_next  = cnt_q - ONE;
      ratio_ext = FN_W'(ratio_q);
      // With a down-counter the output stays high while the cycles left
      // in the period are at least the low-phase length.
      low_len   = RATIO_W'(ratio_ext - high_len(ratio_ext));

      unique case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            div_d   = 1'b0;
            ratio_d = div_ratio;
            if (clk_en && ratio_ok) begin
               state_d = ST_RUN;
               cnt_d   = div_ratio - ONE;
               div_d   = 1'b1;
               tick_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (sync || (cnt_q == '0)) begin
               // A sync that finds a bypass ratio stops the channel rather
               // than restarting it with a period it cannot produce.
               if (clk_en && ratio_ok) begin
                  cnt_d   = div_ratio - ONE;
                  ratio_d = div_ratio;
                  div_d   = 1'b1;
                  tick_d  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  ratio_d = div_ratio;
                  div_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_next;
               div_d = (cnt_next >= low_len);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ratio_q <= '0;
         div_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
      end
   end

   assign running = (state_q == ST_RUN);

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi
// N_CH independent glitch-free clock dividers sharing one reference clock
// and a common phase-alignment sync.
// Ports:
//   I_ref_clk   in   reference clock
//   I_rst       in   synchronous, active-high reset
//   I_clk_en    in   per-channel enable
//   I_div_ratio in   per-channel division ratio
//   I_sync      in   one-cycle pulse restarting all running channels in phase
//   o_div_clk   out  divided clock, or I_ref_clk when the channel is not running
//   o_tick      out  one-cycle pulse at the start of each divided period
//   o_running   out  channel is dividing
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned RATIO_W = 8
) (
   input  logic                          I_ref_clk,
   input  logic                          I_rst,
   input  logic [N_CH-1:0]               I_clk_en,
   input  logic [N_CH-1:0][RATIO_W-1:0]  I_div_ratio,
   input  logic                          I_sync,
   output logic [N_CH-1:0]               o_div_clk,
   output logic [N_CH-1:0]               o_tick,
   output logic [N_CH-1:0]               o_running
);

   logic [N_CH-1:0] div_q;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      clk_div_chan #(
         .RATIO_W (RATIO_W)
      ) u_chan (
         .clk_sys   (I_ref_clk),
         .rst       (I_rst),
         .clk_en    (I_clk_en[gi]),
         .div_ratio (I_div_ratio[gi]),
         .sync      (I_sync),
         .div_q     (div_q[gi]),
         .tick_q    (o_tick[gi]),
         .running   (o_running[gi])
      );

      // Kept as a lone assign so it can be swapped for a clock-mux cell.
      assign o_div_clk[gi] = o_running[gi] ? div_q[gi] : I_ref_clk;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

   localparam int N_CH    = 4;
   localparam int RATIO_W = 8;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic [N_CH-1:0]              en = '0;
   logic [N_CH-1:0][RATIO_W-1:0] ratio = '0;
   logic                         sync = 1'b0;
   logic [N_CH-1:0]              div_clk;
   logic [N_CH-1:0]              tick;
   logic [N_CH-1:0]              running;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   clk_div_multi #(
      .N_CH    (N_CH),
      .RATIO_W (RATIO_W)
   ) dut (
      .I_ref_clk   (clk),
      .I_rst       (rst),
      .I_clk_en    (en),
      .I_div_ratio (ratio),
      .I_sync      (sync),
      .o_div_clk   (div_clk),
      .o_tick      (tick),
      .o_running   (running)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Time-based model: each running channel remembers the cycle its
   // current period began and that period's ratio.
   int n = 0;
   bit m_run [N_CH];
   int m_t0  [N_CH];
   int m_r   [N_CH];

   always @(posedge clk) begin : model
      int rin;
      bit ok;
      n = n + 1;
      for (int c = 0; c < N_CH; c++) begin
         rin = int'(ratio[c]);
         ok  = en[c] && (rin >= 2);
         if (rst) begin
            m_run[c] = 1'b0;
         end else if (!m_run[c]) begin
            if (ok) begin
               m_run[c] = 1'b1;
               m_t0[c]  = n;
               m_r[c]   = rin;
            end
         end else if (sync || ((n - 1 - m_t0[c]) == m_r[c] - 1)) begin
            if (ok) begin
               m_t0[c] = n;
               m_r[c]  = rin;
            end else begin
               m_run[c] = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin : compare
      int p;
      bit e_div;
      bit e_tick;
      #1;
      if (chk_en) begin
         for (int c = 0; c < N_CH; c++) begin
            p      = n - m_t0[c];
            e_div  = m_run[c] ? (p < (m_r[c] + 1) / 2) : clk;
            e_tick = m_run[c] && (p == 0);
            check($sformatf("model_div ch%0d cyc%0d", c, n), int'(div_clk[c]), int'(e_div));
            check($sformatf("model_tick ch%0d cyc%0d", c, n), int'(tick[c]), int'(e_tick));
            check($sformatf("model_run ch%0d cyc%0d", c, n), int'(running[c]), int'(m_run[c]));
         end
      end
   end

   task automatic measure(input int ch, input int cycles, output int highs, output int ticks);
      highs = 0;
      ticks = 0;
      repeat (cycles) begin
         @(negedge clk);
         highs += int'(div_clk[ch]);
         ticks += int'(tick[ch]);
      end
   endtask

   task automatic wait_idle(input int ch, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (!running[ch]) done = 1'b1;
      end
      check($sformatf("idle_wait ch%0d", ch), int'(done), 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      int rt [3];
      int hx [3];
      int h;
      int t;
      int cnt;
      int mis;
      logic [13:0] hist_div;
      logic [13:0] hist_tick;

      rt = '{4, 5, 7};
      hx = '{20, 30, 40};

      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_running", int'(running), 0);
      check("reset_tick", int'(tick), 0);
      rst = 1'b0;

      for (int k = 0; k < 3; k++) begin
         ratio[0] = RATIO_W'(rt[k]);
         en[0]    = 1'b1;
         measure(0, 10 * rt[k], h, t);
         check($sformatf("high_cycles r%0d", rt[k]), h, hx[k]);
         check($sformatf("ticks r%0d", rt[k]), t, 10);
         en[0] = 1'b0;
         wait_idle(0, 20);
      end

      ratio[0] = 8'd4;
      en[0]    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ratio[0] = 8'd6;
      hist_div  = '0;
      hist_tick = '0;
      for (int i = 0; i < 14; i++) begin
         if (i > 0) @(negedge clk);
         hist_div  = {hist_div[12:0], div_clk[0]};
         hist_tick = {hist_tick[12:0], tick[0]};
      end
      check("ratio_change_div", int'(hist_div), int'(14'b10011100011100));
      check("ratio_change_tick", int'(hist_tick), int'(14'b00010000010000));
      en[0] = 1'b0;
      wait_idle(0, 20);

      ratio[0] = 8'd8;
      en[0]    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      en[0] = 1'b0;
      cnt = int'(running[0]);
      repeat (9) begin
         @(negedge clk);
         cnt += int'(running[0]);
      end
      check("disable_drain_cycles", cnt, 6);
      @(posedge clk);
      #1;
      check("disable_bypass", int'(div_clk[0]), 1);
      @(negedge clk);

      ratio[0] = 8'd6;
      ratio[1] = 8'd6;
      ratio[2] = 8'd0;
      ratio[3] = 8'd1;
      en       = 4'b1101;
      repeat (2) @(negedge clk);
      en[1] = 1'b1;
      repeat (5) @(negedge clk);
      check("bypass_ratio01_running", int'(running[3:2]), 0);
      check("sync_pre_running", int'(running[1:0]), 3);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      check("sync_tick", int'(tick[1:0]), 3);
      check("sync_div", int'(div_clk[1:0]), 3);
      mis = 0;
      cnt = 0;
      repeat (24) begin
         @(negedge clk);
         if (div_clk[0] != div_clk[1] || tick[0] != tick[1]) mis++;
         cnt += int'(tick[0]);
      end
      check("sync_aligned_mismatches", mis, 0);
      check("sync_ticks", cnt, 4);
      en = '0;
      wait_idle(0, 20);
      wait_idle(1, 20);

      ratio    = '0;
      ratio[0] = 8'd10;
      en[0]    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_running", int'(running), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_bypass", int'(div_clk), 15);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("restart_tick", int'(tick[0]), 1);
      check("restart_running", int'(running[0]), 1);
      check("restart_div", int'(div_clk[0]), 1);
      @(negedge clk);
      en[0] = 1'b0;
      wait_idle(0, 20);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider, a parametrised successor to the single-channel divider in the system clock tree. It provides N_CH independent divided clocks from one reference clock, each with its own enable and division ratio. Ratio changes and disables take effect only at period boundaries, so the outputs never produce runt pulses. A common sync input phase-aligns all running channels. It feeds the UART and peripheral clock domains, and each channel also drives a single-cycle tick output for the control logic.

## Interface
- N_CH, 4, number of independent divider channels
- RATIO_W, 8, width of each division-ratio field
- I_ref_clk  input  1  reference clock; all state changes on its rising edge
- I_rst  input  1  synchronous, active-high reset
- I_clk_en  input  N_CH  per-channel enable
- I_div_ratio  input  N_CH x RATIO_W  per-channel division ratio, packed [N_CH-1:0][RATIO_W-1:0]
- I_sync  input  1  single-cycle pulse; restarts all running channels in phase
- o_div_clk  output  N_CH  divided clock per channel (I_ref_clk when not running)
- o_tick  output  N_CH  registered one-cycle pulse, asserted in the first cycle of each high phase
- o_running  output  N_CH  channel is in RUN

## Operation
- Per-channel state is IDLE or RUN. Each channel keeps a count of RATIO_W bits (0..R-1), a shadow ratio R, and the div_q, tick and state registers.
- High length is H = R - (R>>1), i.e. ceil(R/2); low length is R>>1.
  - Even R gives 50 % duty.
  - Odd R is high one cycle longer than it is low.
- IDLE:
  - Each cycle: count=0, div_q=0, tick=0, and R is loaded from I_div_ratio.
  - If I_clk_en=1 and I_div_ratio>=2: go to RUN with count=0, div_q=1, tick=1.
  - Otherwise stay in IDLE.
- RUN, count != R-1: count+1; div_q = (count+1 < H); tick=0.
- RUN, count == R-1 (period end):
  - If I_clk_en=0 or I_div_ratio<2: go to IDLE (div_q=0).
  - Otherwise: count=0, R loaded from I_div_ratio, div_q=1, tick=1.
- Changes to I_div_ratio in mid-period are ignored until the period end.
- A disable in mid-period completes the current period before the channel stops.
- Output mux: o_div_clk = RUN ? div_q : I_ref_clk.
  - Ratio 0 or 1 therefore gives bypass.
  - Disabled channels also output I_ref_clk.
- I_sync=1:
  - Every channel in RUN with I_clk_en=1 restarts with count=0, R loaded from I_div_ratio, div_q=1, tick=1.
  - A channel in RUN with I_clk_en=0 goes to IDLE.
  - Channels in IDLE behave normally.
- Priority: I_rst > I_sync > period-end logic > count increment.

## Timing
- Reset values: state=IDLE, count=0, R=0, div_q=0, o_tick=0, o_running=0, o_div_clk=I_ref_clk.
- Start latency: if I_clk_en is sampled high at edge k, div_q and o_tick are high after edge k. The first period is R cycles from edge k.
- o_tick is high for exactly 1 cycle per divided period.
- o_running follows state, with no extra latency.
- Ratio update: a ratio presented before the period-end edge is used starting with the following period.
- Sync: all affected channels have div_q=1 after the same edge and remain edge-aligned while their ratios are equal.
- Reset is taken at the first rising edge with I_rst=1, and also in mid-period; the same cycle produces the reset values. The mux output is bypass immediately after that edge.
- The maximum ratio is 2^RATIO_W-1; count never exceeds R-1, so it does not wrap.

## Structure
- Shared package clk_div_pkg contains:
  - the state enum (IDLE, RUN)
  - function high_len(R), returning R - (R>>1)
  - constant MIN_RATIO = 2
- Sub-module clk_div_chan holds one channel (state, count, shadow R, div_q, tick).
- The top level generates N_CH instances and fans out I_sync and the I_rst/I_ref_clk pair.
- The clock mux is isolated in a single assign per channel, so that synthesis can replace it with a clock-gating cell.

## Test plan
- Enable channel 0 with ratio 4 → o_div_clk is high 2 cycles, low 2 cycles, repeating; o_tick is one cycle every 4 cycles.
- Ratio 5 → high 3 cycles, low 2 cycles. Ratio 7 → high 4 cycles, low 3 cycles. Check over 10 periods.
- Ratio 4 running, change to 6 at count=1 → the current period finishes at 4 cycles, then periods of 6 cycles (3 high, 3 low). No runt pulse.
- Ratio 8 running, drop I_clk_en at count=2 → the channel stays in RUN until count=7, then goes to IDLE, and o_div_clk becomes I_ref_clk.
- Channels 0/1 at ratio 6, started 2 cycles apart; pulse I_sync → both have div_q=1 and o_tick=1 on the same cycle and stay aligned afterwards. Ratio 0 and ratio 1 give o_running=0 and bypass.
- Assert I_rst during the high phase with ratio 10 → the next cycle shows all reset values. After release, with the enable held, the channel restarts with o_tick one edge after release.
